// File: rtl/led_scan_ctrl.sv
// Row scan sequencer for a four-channel LED panel shift chain: row fetch handshake,
// channel select, shift-clock enable, latch and blanking. Optional LED_SCAN_FRAME_PULSE_EN adds frame_done.
module led_scan_ctrl #(
   parameter int CH_BITS      = 32,
   parameter int ROWS         = 16,
   parameter int ROW_W        = $clog2(ROWS),
   parameter int BLANK_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             row_valid,
   output logic             row_ack,
   output logic [ROW_W-1:0] next_row,
   output logic [1:0]       sel,
   output logic             sclk_en,
   output logic             lat,
   output logic             oe_n,
   output logic [ROW_W-1:0] row_addr
`ifdef LED_SCAN_FRAME_PULSE_EN
   ,
   output logic             frame_done
`endif
);

   localparam int SHIFT_LEN = 4 * CH_BITS;
   localparam int CNT_MAX   = (SHIFT_LEN > BLANK_CYCLES) ? SHIFT_LEN : BLANK_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SHIFT,
      LATCH,
      BLANK
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             shown_q;
   logic [1:0]       sel_d;
   logic             row_ack_d;
   logic             oe_n_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (en) state_d = WAIT;
         end
         WAIT: begin
            if (!en) begin
               state_d = IDLE;
            end else if (row_valid) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_W'(SHIFT_LEN - 1)) state_d = LATCH;
            else                                 cnt_d   = cnt_q + 1'b1;
         end
         LATCH: begin
            state_d = BLANK;
            cnt_d   = '0;
         end
         BLANK: begin
            if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = en ? WAIT : IDLE;
            else                                    cnt_d   = cnt_q + 1'b1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so the registered copies line up with state_q
      sel_d = 2'd3;
      if (state_d == SHIFT) sel_d = 2'(32'(cnt_d) / 32'(CH_BITS));
      row_ack_d = (state_d == SHIFT) && (cnt_d == CNT_W'(CH_BITS));
      oe_n_d    = !(shown_q && ((state_d == WAIT) || (state_d == SHIFT)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sel        <= 2'd3;
         sclk_en    <= 1'b0;
         lat        <= 1'b0;
         oe_n       <= 1'b1;
         row_ack    <= 1'b0;
         row_addr   <= '0;
         next_row   <= '0;
         shown_q    <= 1'b0;
`ifdef LED_SCAN_FRAME_PULSE_EN
         frame_done <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel     <= sel_d;
         row_ack <= row_ack_d;
         oe_n    <= oe_n_d;
         // One cycle behind SHIFT to match the shift register's output register
         sclk_en <= (state_q == SHIFT);
         lat     <= (state_q == LATCH);
         if (state_q == LATCH) begin
            row_addr <= next_row;
            next_row <= (next_row == ROW_W'(ROWS - 1)) ? '0 : next_row + 1'b1;
            shown_q  <= 1'b1;
         end
`ifdef LED_SCAN_FRAME_PULSE_EN
         frame_done <= (state_d == LATCH) && (next_row == ROW_W'(ROWS - 1));
`endif
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized bench for led_scan_ctrl: a row-timeline reference model plus a
// behavioural four-channel shift register to check the serial bit order.
module tb_led_scan_ctrl;

   localparam int CH_BITS      = 32;
   localparam int ROWS         = 16;
   localparam int ROW_W        = 4;
   localparam int BLANK_CYCLES = 4;
   localparam int SH           = 4 * CH_BITS;
   localparam int PERIOD       = SH + 1 + BLANK_CYCLES + 1;

   logic             clk = 1'b0;
   logic             rst, en, row_valid;
   logic             row_ack, sclk_en, lat, oe_n;
   logic [1:0]       sel;
   logic [ROW_W-1:0] next_row, row_addr;
`ifdef LED_SCAN_FRAME_PULSE_EN
   logic             frame_done;
`endif

   always #5 clk = ~clk;

   led_scan_ctrl #(
      .CH_BITS      (CH_BITS),
      .ROWS         (ROWS),
      .ROW_W        (ROW_W),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .row_valid (row_valid),
      .row_ack   (row_ack),
      .next_row  (next_row),
      .sel       (sel),
      .sclk_en   (sclk_en),
      .lat       (lat),
      .oe_n      (oe_n),
      .row_addr  (row_addr)
`ifdef LED_SCAN_FRAME_PULSE_EN
      ,
      .frame_done(frame_done)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference model: position within the row timeline (-1 = not in a row)
   int   m_pos;
   bit   m_idle, m_shown;
   int   m_row, m_nrow;

   // Downstream shift register model and serial capture
   logic [1:0]   sel_s;
   logic [31:0]  rA, rB, rC, rD;
   logic [31:0]  sa, sb, sc, sd;
   logic         sdo;
   logic [127:0] col, pend;
   int           ncol;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos   = -1;
      m_idle  = 1'b1;
      m_shown = 1'b0;
      m_row   = 0;
      m_nrow  = 0;
      col     = '0;
      ncol    = 0;
      sel_s   = 2'd3;
   endtask

   task automatic model_update();
      if (m_pos < 0) begin
         if (m_idle) begin
            if (en) m_idle = 1'b0;
         end else if (!en) begin
            m_idle = 1'b1;
         end else if (row_valid) begin
            m_pos = 0;
         end
      end else if (m_pos < SH + BLANK_CYCLES) begin
         m_pos++;
         if (m_pos == SH + 1) begin
            m_row   = m_nrow;
            m_nrow  = (m_nrow + 1) % ROWS;
            m_shown = 1'b1;
         end
      end else begin
         m_pos  = -1;
         m_idle = !en;
      end
   endtask

   task automatic check_outputs();
      bit act;
      act = (m_pos >= 0) && (m_pos < SH);
      chk("sel",      128'(sel),      128'(act ? m_pos / CH_BITS : 3));
      chk("row_ack",  128'(row_ack),  128'(m_pos == CH_BITS));
      chk("sclk_en",  128'(sclk_en),  128'((m_pos >= 1) && (m_pos <= SH)));
      chk("lat",      128'(lat),      128'(m_pos == SH + 1));
      chk("oe_n",     128'(oe_n),     128'(!(m_shown && (act || (m_pos < 0 && !m_idle)))));
      chk("row_addr", 128'(row_addr), 128'(m_row));
      chk("next_row", 128'(next_row), 128'(m_nrow));
`ifdef LED_SCAN_FRAME_PULSE_EN
      chk("frame_done", 128'(frame_done), 128'((m_pos == SH) && (m_nrow == ROWS - 1)));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      case (sel_s)
         2'd0: begin sdo = sa[31]; sa = {sa[30:0], 1'b0}; sd = rD; end
         2'd1: begin sdo = sb[31]; sb = {sb[30:0], 1'b0}; end
         2'd2: begin sdo = sc[31]; sc = {sc[30:0], 1'b0}; end
         default: begin sdo = sd[31]; sd = {sd[30:0], 1'b0}; sa = rA; sb = rB; sc = rC; end
      endcase
      if (rst) model_reset();
      else     model_update();
      @(negedge clk);
      check_outputs();
      sel_s = sel;
      if (sclk_en) begin
         col = {col[126:0], sdo};
         ncol++;
      end
      if (!rst && m_pos == CH_BITS) begin
         pend = {rA, rB, rC, rD};
         rA = $urandom; rB = $urandom; rC = $urandom; rD = $urandom;
      end
      if (!rst && m_pos == SH) begin
         chk("chain_bits", col, pend);
         chk("chain_len", 128'(ncol), 128'(SH));
         ncol = 0;
      end
   endtask

   task automatic run_until(input int target, input int limit);
      int n;
      n = 0;
      while (m_pos != target && n < limit) begin
         step();
         n++;
      end
      if (m_pos != target) chk("timeout_pos", 128'(m_pos), 128'(target));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; row_valid = 1'b0;
      rA = 32'h8000_0001; rB = 32'h0; rC = 32'hFFFF_FFFF; rD = 32'h0000_00AA;
      sa = '0; sb = '0; sc = '0; sd = '0; sdo = 1'b0; pend = '0;
      model_reset();
      #2;
      check_outputs();
      repeat (3) step();
      rst = 1'b0; en = 1'b1; row_valid = 1'b1;

      // Continuous rows: covers the full 16-row wrap and the row period
      repeat (17 * PERIOD + 10) step();

      // Upstream stall in WAIT after a row
      run_until(SH + BLANK_CYCLES, 2 * PERIOD);
      row_valid = 1'b0;
      repeat (50) step();
      row_valid = 1'b1;
      repeat (PERIOD) step();

      // Random row_valid gaps and occasional enable toggles
      for (int i = 0; i < 4000; i++) begin
         row_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) en = !en;
         step();
      end
      en = 1'b1; row_valid = 1'b1;

      // Enable dropped mid-row
      run_until(40, 3 * PERIOD);
      en = 1'b0;
      repeat (2 * PERIOD) step();
      en = 1'b1;

      // Asynchronous reset mid-shift
      run_until(70, 3 * PERIOD);
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      repeat (2) step();
      rst = 1'b0;
      repeat (2 * PERIOD) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Sequencer for the LED panel parallel-in/serial-out shift register (four 32-bit channel words A–D shifted MSB first on one serial line).
- Drives the 2-bit channel select, requests row data upstream with a valid/ack handshake, and generates the panel's shift-clock enable, latch and output-enable.
- Steps through the panel rows one after another.
- Sits between the frame buffer reader (upstream) and the shift register plus panel pins (downstream).

Parameters:
- CH_BITS, 32, bits per channel word; must equal the shift register width. Channel count is fixed at 4, so sel is 2 bits.
- ROWS, 16, panel scan rows; any value ≥2.
- ROW_W, $clog2(ROWS), row address width.
- BLANK_CYCLES, 4, blanking cycles after each latch; ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable.
- row_valid  in  1  upstream presents rA..rD for next_row.
- row_ack  out  1  one-cycle pulse: all four words for next_row captured.
- next_row  out  ROW_W  row whose data is requested.
- sel  out  2  channel select to the shift register.
- sclk_en  out  1  panel shift clock enable; high while the serial data is valid.
- lat  out  1  panel latch pulse.
- oe_n  out  1  panel output enable, active low.
- row_addr  out  ROW_W  row currently displayed.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, sel=3, sclk_en=0, lat=0, oe_n=1, row_ack=0.
  - row_addr=0, next_row=0, shown=0.
- All outputs are registered.
- sel parks at 3 in every state except SHIFT. While parked, the shift register reloads A/B/C every cycle.
- States:
  - IDLE: wait for en=1, then go to WAIT.
  - WAIT: if en=0, go to IDLE. If row_valid=1, go to SHIFT with cnt=0.
  - SHIFT: runs 4*CH_BITS cycles with cnt=0..4*CH_BITS-1.
    - sel=cnt/CH_BITS.
    - row_ack=1 for exactly one cycle, when cnt==CH_BITS (sel has just become 1). By then A/B/C were captured in the last parked cycle and D during the sel=0 cycles.
    - Upstream must hold rA..rD stable from row_valid until row_ack.
    - After the last count, go to LATCH.
  - LATCH: one cycle.
    - lat=1 and oe_n=1 in the following cycle.
    - row_addr<=next_row.
    - next_row<=next_row+1, wrapping ROWS-1→0.
    - shown<=1.
    - Then go to BLANK.
  - BLANK: BLANK_CYCLES cycles with oe_n=1. Then go to WAIT if en=1, else IDLE.
- sclk_en is the state==SHIFT flag delayed one cycle; this accounts for the shift register's one-cycle data_out latency.
  - Exactly 4*CH_BITS sclk_en cycles per row.
  - The last sclk_en cycle coincides with the LATCH state cycle.
  - lat rises the cycle after the last sclk_en.
- oe_n=0 in WAIT and SHIFT only when shown=1; otherwise 1.
  - IDLE forces oe_n=1.
  - Display of the previous row continues while the next row shifts.
- en dropped mid-row: the current row completes through LATCH/BLANK, then IDLE. A new row never starts with en=0.
- row_valid low in WAIT: stay in WAIT indefinitely; display unaffected.
- row_valid is ignored outside WAIT.
- Reset mid-SHIFT: abort immediately. The partially shifted row is never latched. next_row restarts at 0.
- Row period with row_valid always high: 4*CH_BITS+1+BLANK_CYCLES+1 = 134 cycles at the defaults.

Optional Feature:
- Macro: LED_SCAN_FRAME_PULSE_EN.
- Defined: adds output frame_done (1 bit, reset 0). It pulses for one cycle in the LATCH cycle where next_row wraps from ROWS-1 to 0.
- Undefined: port absent; no other behaviour change.

Test Plan:
- Reset release, en=1, row_valid=1 held: sel is 3 until SHIFT, then 0×32, 1×32, 2×32, 3×32.
  - row_ack high for exactly one cycle, at SHIFT cycle 32.
  - sclk_en high for exactly 128 consecutive cycles, starting one cycle after SHIFT entry.
  - lat pulse the cycle after the last sclk_en.
  - oe_n high for 5 cycles.
  - Next SHIFT starts 134 cycles after the first.
- Full chain with the shift register (rA=32'h8000_0001, rB=0, rC=32'hFFFF_FFFF, rD=32'h0000_00AA): serial bits sampled on sclk_en give exactly the 128-bit MSB-first concatenation A,B,C,D.
- 16 rows: row_addr goes 0..15 then 0, with next_row one ahead. oe_n stays 1 until the first latch completes. With LED_SCAN_FRAME_PULSE_EN, frame_done pulses once per 16 rows.
- row_valid low for 50 cycles in WAIT after row 0: sel stays 3, oe_n=0, no sclk_en, no row_ack. Scan resumes 1 cycle after row_valid rises.
- en dropped at SHIFT cycle 40: row completes (128 sclk_en, lat, blank), then IDLE with oe_n=1 and no further row_ack.
- rst asserted at SHIFT cycle 70: outputs reach reset values without waiting for a clock edge; no lat occurs. After release, next_row=0 and row_addr=0.
